// File: rtl/fft_pkg.sv
// Shared FFT types, sizes and the bit-reversal helper used by the output reorder path.
package fft_pkg;
    localparam int FFT_N     = 256;
    localparam int FFT_LOG2N = 8;
    localparam int FFT_DW    = 16;

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;

    // Reverses the low 'width' bits of idx; bits above width come out zero.
    function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] idx,
                                                    input int width);
        logic [FFT_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < FFT_LOG2N; i++) begin
            if (i < width) r[i] = idx[width-1-i];
        end
        return r;
    endfunction
endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Valid/ready complex-sample stream; master drives data, slave drives rdy.
interface fft_stream_if #(parameter int DW = 16);
    logic                 vld;
    logic                 rdy;
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic                 last;

    modport master (output vld, re, im, last, input rdy);
    modport slave  (input vld, re, im, last, output rdy);
endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame store: one synchronous write port, one combinational read port.
module fft_pingpong_ram
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N
) (
    input  logic             clk,
    input  logic             we,
    input  logic             wr_bank,
    input  logic [LOG2N-1:0] wr_addr,
    input  cplx_t            wdata,
    input  logic             rd_bank,
    input  logic [LOG2N-1:0] rd_addr,
    output cplx_t            rdata
);
    cplx_t mem [2*N];

    always_ff @(posedge clk) begin
        if (we) mem[{wr_bank, wr_addr}] <= wdata;
    end

    assign rdata = mem[{rd_bank, rd_addr}];
endmodule

// File: rtl/fft_bitrev_reorder.sv
// Stores bit-reversed FFT frames into ping-pong banks and replays them in natural bin order.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N,
    parameter int DW    = FFT_DW
) (
    input  logic             clk,
    input  logic             rst_n,
    fft_stream_if.slave      s,
    fft_stream_if.master     m,
    output logic [LOG2N-1:0] out_idx,
    output logic             frame_err
);
    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

    logic [LOG2N-1:0] wr_cnt, rd_cnt;
    logic             wr_bank, rd_bank;
    logic [1:0]       bank_full;
    logic [1:0]       set_v, clr_v;
    logic             in_rdy, acc, wr_end, load, rd_end;
    logic             out_vld, out_last;
    cplx_t            out_d, wdata, rdata;

    assign in_rdy = !bank_full[wr_bank];
    assign acc    = s.vld && in_rdy;
    assign wr_end = (wr_cnt == CNT_LAST);
    assign load   = bank_full[rd_bank] && (!out_vld || m.rdy);
    assign rd_end = (rd_cnt == CNT_LAST);

    // A bank can only be set while empty and cleared while full, so both may apply in one cycle.
    always_comb begin
        set_v = 2'b00;
        clr_v = 2'b00;
        if (acc && wr_end) set_v[wr_bank] = 1'b1;
        if (load && rd_end) clr_v[rd_bank] = 1'b1;
    end

    assign wdata.re = s.re;
    assign wdata.im = s.im;

    fft_pingpong_ram #(.N(N), .LOG2N(LOG2N)) u_ram (
        .clk     (clk),
        .we      (acc),
        .wr_bank (wr_bank),
        .wr_addr (bitrev(wr_cnt, LOG2N)),
        .wdata   (wdata),
        .rd_bank (rd_bank),
        .rd_addr (rd_cnt),
        .rdata   (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= 2'b00;
            out_vld   <= 1'b0;
            out_last  <= 1'b0;
            out_d     <= '0;
            out_idx   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            bank_full <= (bank_full | set_v) & ~clr_v;
            if (acc) begin
                if (wr_end) begin
                    wr_cnt    <= '0;
                    wr_bank   <= ~wr_bank;
                    frame_err <= !s.last;
                end else if (s.last) begin
                    // Short frame: drop it and restart the same bank from address 0.
                    wr_cnt    <= '0;
                    frame_err <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (load) begin
                out_d    <= rdata;
                out_idx  <= rd_cnt;
                out_last <= rd_end;
                out_vld  <= 1'b1;
                if (rd_end) begin
                    rd_cnt  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end else if (out_vld && m.rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

    assign s.rdy  = in_rdy;
    assign m.vld  = out_vld;
    assign m.re   = out_d.re;
    assign m.im   = out_d.im;
    assign m.last = out_last;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for the bit-reversal reorder buffer: ordering, framing, backpressure and reset.
module tb_fft_bitrev_reorder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] out_idx;
    logic       frame_err;
    int         vectors = 0;
    int         misc = 0;
    int         cyc = 0;
    int         err_cnt = 0;

    fft_stream_if #(.DW(16)) in_if ();
    fft_stream_if #(.DW(16)) out_if ();

    fft_bitrev_reorder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (in_if.slave),
        .m         (out_if.master),
        .out_idx   (out_idx),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;
    always @(negedge clk) if (frame_err === 1'b1) err_cnt = err_cnt + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] gen_re(input int tag, input int i);
        return 16'(tag * 256 + i);
    endfunction

    function automatic logic [15:0] gen_im(input int tag, input int i);
        return 16'(tag * 7 - i);
    endfunction

    function automatic int bitrev8(input int k);
        logic [7:0] a, b;
        a = 8'(k);
        for (int j = 0; j < 8; j++) b[j] = a[7-j];
        return int'(b);
    endfunction

    task automatic send_frame(input int tag, input int nsamp, input int last_at,
                              output int first_cyc, output int last_cyc);
        int t;
        first_cyc = -1;
        last_cyc  = -1;
        for (int i = 0; i < nsamp; i++) begin
            @(negedge clk);
            in_if.vld  = 1'b1;
            in_if.re   = gen_re(tag, i);
            in_if.im   = gen_im(tag, i);
            in_if.last = (i == last_at);
            t = 0;
            while (in_if.rdy !== 1'b1 && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 3000) begin
                vectors++; misc++;
                $display("FAIL send_timeout tag=%0d sample=%0d in_rdy stayed low", tag, i);
                break;
            end
            @(posedge clk);
            #1;
            if (i == 0) first_cyc = cyc;
            last_cyc = cyc;
        end
        @(negedge clk);
        in_if.vld  = 1'b0;
        in_if.last = 1'b0;
    endtask

    // mode 0: out_rdy held high; mode 1: out_rdy random per cycle
    task automatic recv_frame(input int tag, input int mode,
                              output int first_cyc, output int last_cyc);
        int k, t;
        logic rdy, hold;
        logic [41:0] held, now;
        k = 0; t = 0; hold = 1'b0; held = '0;
        first_cyc = -1;
        last_cyc  = -1;
        while (k < 256 && t < 5000) begin
            @(negedge clk);
            t++;
            now = {out_if.vld, out_if.re, out_if.im, out_if.last, out_idx};
            if (hold) begin
                vectors++;
                if (now !== held) begin
                    misc++;
                    $display("FAIL hold_stable tag=%0d bin=%0d got=%h want=%h", tag, k, now, held);
                end
            end
            rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            out_if.rdy = rdy;
            hold = 1'b0;
            if (out_if.vld === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (rdy) begin
                    vectors += 4;
                    if (out_idx !== 8'(k)) begin
                        misc++;
                        $display("FAIL out_idx tag=%0d got=%0d want=%0d", tag, out_idx, k);
                    end
                    if (out_if.re !== gen_re(tag, bitrev8(k))) begin
                        misc++;
                        $display("FAIL out_re tag=%0d bin=%0d got=%0d want=%0d", tag, k,
                                 out_if.re, $signed(gen_re(tag, bitrev8(k))));
                    end
                    if (out_if.im !== gen_im(tag, bitrev8(k))) begin
                        misc++;
                        $display("FAIL out_im tag=%0d bin=%0d got=%0d want=%0d", tag, k,
                                 out_if.im, $signed(gen_im(tag, bitrev8(k))));
                    end
                    if (out_if.last !== (k == 255)) begin
                        misc++;
                        $display("FAIL out_last tag=%0d bin=%0d got=%b want=%b", tag, k,
                                 out_if.last, (k == 255));
                    end
                    if (k == 255) last_cyc = cyc;
                    k++;
                end else begin
                    hold = 1'b1;
                    held = now;
                end
            end
        end
        if (k < 256) begin
            vectors++; misc++;
            $display("FAIL recv_timeout tag=%0d got=%0d transfers want=256", tag, k);
        end
    endtask

    task automatic expect_idle(input string name, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            vectors++;
            if (out_if.vld !== 1'b0) begin
                misc++;
                $display("FAIL %s out_vld got=%b want=0", name, out_if.vld);
            end
        end
    endtask

    task automatic test_reset();
        in_if.vld = 1'b0; in_if.re = '0; in_if.im = '0; in_if.last = 1'b0;
        out_if.rdy = 1'b0;
        rst_n = 1'b0;
        #23;
        vectors += 7;
        if (out_if.vld !== 1'b0)  begin misc++; $display("FAIL rst_out_vld got=%b want=0", out_if.vld); end
        if (out_if.last !== 1'b0) begin misc++; $display("FAIL rst_out_last got=%b want=0", out_if.last); end
        if (out_if.re !== 16'sd0) begin misc++; $display("FAIL rst_out_re got=%0d want=0", out_if.re); end
        if (out_if.im !== 16'sd0) begin misc++; $display("FAIL rst_out_im got=%0d want=0", out_if.im); end
        if (out_idx !== 8'd0)     begin misc++; $display("FAIL rst_out_idx got=%0d want=0", out_idx); end
        if (frame_err !== 1'b0)   begin misc++; $display("FAIL rst_frame_err got=%b want=0", frame_err); end
        if (in_if.rdy !== 1'b1)   begin misc++; $display("FAIL rst_in_rdy got=%b want=1", in_if.rdy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ramp();
        int sf, sl, rf, rl, e0;
        e0 = err_cnt;
        fork
            send_frame(0, 256, 255, sf, sl);
            recv_frame(0, 0, rf, rl);
        join
        vectors += 2;
        if (rf !== sl + 1) begin
            misc++;
            $display("FAIL ramp_latency first out_vld cycle got=%0d want=%0d", rf, sl + 1);
        end
        if (err_cnt !== e0) begin
            misc++;
            $display("FAIL ramp_frame_err pulses got=%0d want=0", err_cnt - e0);
        end
        expect_idle("ramp_no_extra", 3);
    endtask

    task automatic test_backpressure();
        int sf, sl, rf, rl;
        fork
            send_frame(1, 256, 255, sf, sl);
            recv_frame(1, 1, rf, rl);
        join
        out_if.rdy = 1'b1;
        expect_idle("bp_no_duplicate", 4);
    endtask

    task automatic test_early_last();
        int sf, sl, rf, rl, e0;
        e0 = err_cnt;
        send_frame(2, 101, 100, sf, sl);
        expect_idle("early_no_output", 6);
        vectors++;
        if (err_cnt - e0 !== 1) begin
            misc++;
            $display("FAIL early_frame_err pulses got=%0d want=1", err_cnt - e0);
        end
        fork
            send_frame(3, 256, 255, sf, sl);
            recv_frame(3, 0, rf, rl);
        join
        expect_idle("early_next_idle", 3);
    endtask

    task automatic test_missing_last();
        int sf, sl, rf, rl, e0;
        e0 = err_cnt;
        fork
            send_frame(4, 256, -1, sf, sl);
            recv_frame(4, 0, rf, rl);
        join
        repeat (3) @(negedge clk);
        vectors++;
        if (err_cnt - e0 !== 1) begin
            misc++;
            $display("FAIL missing_last_frame_err pulses got=%0d want=1", err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        int af, al, bf, bl, cf, cl, r0, r1;
        out_if.rdy = 1'b0;
        send_frame(5, 256, 255, af, al);
        send_frame(6, 256, 255, bf, bl);
        vectors++;
        if (in_if.rdy !== 1'b0) begin
            misc++;
            $display("FAIL b2b_in_rdy_full got=%b want=0", in_if.rdy);
        end
        fork
            send_frame(7, 256, 255, cf, cl);
            begin
                recv_frame(5, 0, r0, r1);
                al = r1;
                recv_frame(6, 0, r0, r1);
                recv_frame(7, 0, r0, r1);
            end
        join
        vectors++;
        if (cf !== al + 1) begin
            misc++;
            $display("FAIL b2b_c_accept cycle got=%0d want=%0d", cf, al + 1);
        end
        expect_idle("b2b_idle", 3);
    endtask

    task automatic test_reset_mid_drain();
        int sf, sl, rf, rl, t;
        fork
            send_frame(8, 256, 255, sf, sl);
            begin
                out_if.rdy = 1'b1;
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!(out_if.vld === 1'b1 && out_idx === 8'd50) && t < 2000);
            end
        join
        vectors++;
        if (t >= 2000) begin
            misc++;
            $display("FAIL rst_mid_reach out_idx=50 not reached, got=%0d", out_idx);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors += 3;
        if (out_if.vld !== 1'b0) begin misc++; $display("FAIL rst_mid_out_vld got=%b want=0", out_if.vld); end
        if (in_if.rdy !== 1'b1)  begin misc++; $display("FAIL rst_mid_in_rdy got=%b want=1", in_if.rdy); end
        if (out_idx !== 8'd0)    begin misc++; $display("FAIL rst_mid_out_idx got=%0d want=0", out_idx); end
        @(negedge clk);
        rst_n = 1'b1;
        expect_idle("rst_mid_flushed", 3);
        fork
            send_frame(9, 256, 255, sf, sl);
            recv_frame(9, 0, rf, rl);
        join
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_back_to_back();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule
